// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl_pkg
//  Description : Shared definitions for the pipeline hazard controller:
//                instruction codes, register/status codes, control levels,
//                datapath widths, FSM state encodings and small helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    // Datapath widths (byte-wide codes, word-wide counters)
    localparam int BYTE_W = 8;
    localparam int WORD_W = 32;

    // Instruction codes
    localparam logic [BYTE_W-1:0] INOP    = 8'h01;
    localparam logic [BYTE_W-1:0] IMRMOVL = 8'h05;
    localparam logic [BYTE_W-1:0] IJXX    = 8'h07;
    localparam logic [BYTE_W-1:0] IRET    = 8'h09;
    localparam logic [BYTE_W-1:0] IPOPL   = 8'h0B;

    // "No register" identifier
    localparam logic [BYTE_W-1:0] RNONE   = 8'h0F;

    // Status codes
    localparam logic [BYTE_W-1:0] SAOK    = 8'h01;
    localparam logic [BYTE_W-1:0] SHLT    = 8'h02;
    localparam logic [BYTE_W-1:0] SADR    = 8'h03;
    localparam logic [BYTE_W-1:0] SINS    = 8'h04;

    // Pipeline register control levels
    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    // Controller FSM state encodings
    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    // Bundle of the six pipeline register controls
    typedef struct packed {
        logic f_stall;
        logic d_stall;
        logic d_bubble;
        logic e_bubble;
        logic m_bubble;
        logic w_stall;
    } ctl_t;

    localparam ctl_t CTL_IDLE = '{f_stall: DISABLE, d_stall: DISABLE,
                                  d_bubble: DISABLE, e_bubble: DISABLE,
                                  m_bubble: DISABLE, w_stall: DISABLE};

    // A status is exceptional when it stops the machine (address, bad instr, halt)
    function automatic logic is_exc(input logic [BYTE_W-1:0] stat);
        return (stat == SADR) || (stat == SINS) || (stat == SHLT);
    endfunction

    // Loads that write a register from memory and so create load-use hazards
    function automatic logic is_load(input logic [BYTE_W-1:0] icode);
        return (icode == IMRMOVL) || (icode == IPOPL);
    endfunction

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/pipe_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Up counter that sticks at all-ones instead of wrapping.
//                Synchronous active-high reset and synchronous clear.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             at_max;

    assign at_max = &cnt_q;

    // Next count: clear wins, otherwise increment unless already saturated
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !at_max) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl
//  Description : Five-stage pipeline hazard controller. Derives stall and
//                bubble controls from load-use, return and mispredict
//                hazards, drains and halts on exceptions, and keeps
//                saturating stall/bubble performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] D_icode_i,
    input  logic [BYTE_W-1:0] d_srcA_i,
    input  logic [BYTE_W-1:0] d_srcB_i,
    input  logic [BYTE_W-1:0] E_icode_i,
    input  logic [BYTE_W-1:0] E_dstM_i,
    input  logic              e_Cnd_i,
    input  logic [BYTE_W-1:0] M_icode_i,
    input  logic [BYTE_W-1:0] m_stat_i,
    input  logic [BYTE_W-1:0] W_stat_i,
    output logic              F_stall_o,
    output logic              D_stall_o,
    output logic              D_bubble_o,
    output logic              E_bubble_o,
    output logic              M_bubble_o,
    output logic              W_stall_o,
    output logic              halted_o,
    output logic [WORD_W-1:0] stall_cnt_o,
    output logic [WORD_W-1:0] bubble_cnt_o
);

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    logic load_use;
    logic ret_inflight;
    logic mispred;
    logic m_exc;
    logic w_exc;

    // Classify the hazards present in the current cycle
    always_comb begin
        load_use     = is_load(E_icode_i)
                     && (E_dstM_i != RNONE)
                     && ((E_dstM_i == d_srcA_i) || (E_dstM_i == d_srcB_i));
        ret_inflight = (D_icode_i == IRET) || (E_icode_i == IRET)
                     || (M_icode_i == IRET);
        mispred      = (E_icode_i == IJXX) && !e_Cnd_i;
        m_exc        = is_exc(m_stat_i);
        w_exc        = is_exc(W_stat_i);
    end

    // ------------------------------------------------------------------
    // Controller FSM
    // ------------------------------------------------------------------
    logic [1:0] state_q;
    logic [1:0] state_d;

    // State register; reset overrides any pending transition
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a writeback exception halts at once, a memory-stage
    // exception first drains until it reaches writeback; halt is sticky
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (w_exc) begin
                    state_d = ST_HALT;
                end else if (m_exc) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_exc) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control outputs
    // ------------------------------------------------------------------
    ctl_t ctl;

    // Output decode: hazard equations in RUN/DRAIN, frozen pipe in HALT,
    // everything released while reset is held
    always_comb begin
        ctl = CTL_IDLE;
        if (rst) begin
            ctl = CTL_IDLE;
        end else begin
            case (state_q)
                ST_HALT: begin
                    ctl.f_stall  = ENABLE;
                    ctl.d_stall  = ENABLE;
                    ctl.d_bubble = DISABLE;
                    ctl.e_bubble = ENABLE;
                    ctl.m_bubble = ENABLE;
                    ctl.w_stall  = ENABLE;
                end
                default: begin
                    // Load-use stalls decode, so it must not also be
                    // bubbled by an in-flight return
                    ctl.f_stall  = load_use | ret_inflight;
                    ctl.d_stall  = load_use;
                    ctl.d_bubble = mispred | (ret_inflight & ~load_use);
                    ctl.e_bubble = mispred | load_use;
                    ctl.m_bubble = m_exc | w_exc | (state_q == ST_DRAIN);
                    ctl.w_stall  = w_exc;
                end
            endcase
        end
    end

    assign F_stall_o  = ctl.f_stall;
    assign D_stall_o  = ctl.d_stall;
    assign D_bubble_o = ctl.d_bubble;
    assign E_bubble_o = ctl.e_bubble;
    assign M_bubble_o = ctl.m_bubble;
    assign W_stall_o  = ctl.w_stall;
    assign halted_o   = (state_q == ST_HALT) && !rst;

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
    logic stall_inc;
    logic bubble_inc;

    // Count from the controls actually driven; a halted pipe is not counted
    always_comb begin
        stall_inc  = (ctl.f_stall  | ctl.d_stall)  && (state_q != ST_HALT);
        bubble_inc = (ctl.d_bubble | ctl.e_bubble) && (state_q != ST_HALT);
    end

    sat_counter #(
        .WIDTH (WORD_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (1'b0),
        .inc_i (stall_inc),
        .cnt_o (stall_cnt_o)
    );

    sat_counter #(
        .WIDTH (WORD_W)
    ) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (1'b0),
        .inc_i (bubble_inc),
        .cnt_o (bubble_cnt_o)
    );

endmodule : pipe_ctrl
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_ctrl
//  Description : Self-checking bench for pipe_ctrl: directed hazard,
//                exception, saturation and reset scenarios followed by
//                random traffic, all checked against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode, m_stat, W_stat;
    logic        e_Cnd;
    logic        F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, halted;
    logic [31:0] stall_cnt, bubble_cnt;

    int n_vec  = 0;
    int n_fail = 0;

    // Model state: 0 = running, 1 = draining, 2 = halted
    int          m_mode  = 0;
    logic [31:0] m_stall = '0;
    logic [31:0] m_bubble = '0;
    bit          model_on = 1'b0;

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .D_icode_i    (D_icode),
        .d_srcA_i     (d_srcA),
        .d_srcB_i     (d_srcB),
        .E_icode_i    (E_icode),
        .E_dstM_i     (E_dstM),
        .e_Cnd_i      (e_Cnd),
        .M_icode_i    (M_icode),
        .m_stat_i     (m_stat),
        .W_stat_i     (W_stat),
        .F_stall_o    (F_stall),
        .D_stall_o    (D_stall),
        .D_bubble_o   (D_bubble),
        .E_bubble_o   (E_bubble),
        .M_bubble_o   (M_bubble),
        .W_stall_o    (W_stall),
        .halted_o     (halted),
        .stall_cnt_o  (stall_cnt),
        .bubble_cnt_o (bubble_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [5:0] ctl_vec();
        return {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall};
    endfunction

    task automatic idle();
        rst = 1'b0; D_icode = INOP; E_icode = INOP; M_icode = INOP;
        d_srcA = RNONE; d_srcB = RNONE; E_dstM = RNONE; e_Cnd = 1'b1;
        m_stat = SAOK; W_stat = SAOK;
    endtask

    // Reference model: compare this cycle's outputs, then advance by one edge
    task automatic model_check();
        bit lu, ri, mp, me, we;
        bit f, ds, db, eb, mb, ws;
        lu = ((E_icode == IMRMOVL) || (E_icode == IPOPL)) && (E_dstM != RNONE)
             && (E_dstM == d_srcA || E_dstM == d_srcB);
        ri = (D_icode == IRET) || (E_icode == IRET) || (M_icode == IRET);
        mp = (E_icode == IJXX) && (e_Cnd == 1'b0);
        me = (m_stat == SADR) || (m_stat == SINS) || (m_stat == SHLT);
        we = (W_stat == SADR) || (W_stat == SINS) || (W_stat == SHLT);
        if (rst) begin
            {f, ds, db, eb, mb, ws} = 6'b0;
        end else if (m_mode == 2) begin
            {f, ds, db, eb, mb, ws} = 6'b110111;
        end else begin
            f  = lu || ri;
            ds = lu;
            db = mp || (ri && !lu);
            eb = mp || lu;
            mb = me || we || (m_mode == 1);
            ws = we;
        end
        check("ctl", {26'd0, ctl_vec()}, {26'd0, f, ds, db, eb, mb, ws});
        check("halted", {31'd0, halted}, {31'd0, (m_mode == 2) && !rst});
        check("stall_cnt", stall_cnt, m_stall);
        check("bubble_cnt", bubble_cnt, m_bubble);
        if (rst) begin
            m_mode = 0; m_stall = '0; m_bubble = '0;
        end else begin
            if (m_mode != 2) begin
                if ((f || ds) && m_stall  != 32'hFFFF_FFFF) m_stall++;
                if ((db || eb) && m_bubble != 32'hFFFF_FFFF) m_bubble++;
            end
            if (m_mode != 2 && we)        m_mode = 2;
            else if (m_mode == 0 && me)   m_mode = 1;
        end
    endtask

    // Sample half a cycle after the inputs change, away from the active edge
    task automatic eval();
        @(negedge clk); #1;
        if (model_on) model_check();
    endtask

    task automatic advance();
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0] icodes [6];
        icodes = '{INOP, IJXX, IMRMOVL, IPOPL, IRET, 8'h00};

        // ---------------- Reset ----------------
        idle(); rst = 1'b1;
        advance();
        model_on = 1'b1;
        eval();
        check("rst_ctl", {26'd0, ctl_vec()}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        advance();
        idle();
        eval();
        check("post_rst_stall", stall_cnt, 32'd0);
        check("post_rst_bubble", bubble_cnt, 32'd0);
        check("post_rst_ctl", {26'd0, ctl_vec()}, 32'd0);
        advance();

        // ---------------- Load-use ----------------
        E_icode = IMRMOVL; E_dstM = 8'd3; d_srcA = 8'd3;
        eval();
        check("lu_ctl", {26'd0, ctl_vec()}, {26'd0, 6'b110100});
        advance();
        idle();
        eval();
        check("lu_stall_cnt", stall_cnt, 32'd1);
        check("lu_bubble_cnt", bubble_cnt, 32'd1);
        advance();

        // ---------------- Return moving D -> E -> M ----------------
        for (int i = 0; i < 3; i++) begin
            idle();
            if (i == 0) D_icode = IRET;
            if (i == 1) E_icode = IRET;
            if (i == 2) M_icode = IRET;
            eval();
            check("ret_ctl", {26'd0, ctl_vec()}, {26'd0, 6'b101000});
            advance();
        end
        idle();
        eval();
        check("ret_bubble_cnt", bubble_cnt, 32'd4);
        check("ret_stall_cnt", stall_cnt, 32'd4);
        advance();

        // ---------------- Mispredict with return in decode ----------------
        E_icode = IJXX; e_Cnd = 1'b0; D_icode = IRET;
        eval();
        check("mp_ret_ctl", {26'd0, ctl_vec()}, {26'd0, 6'b101100});
        advance();
        idle();
        eval();
        check("mp_bubble_cnt", bubble_cnt, 32'd5);
        advance();

        // ---------------- Exception: drain then halt ----------------
        m_stat = SADR;
        eval();
        check("exc_m_ctl", {26'd0, ctl_vec()}, {26'd0, 6'b000010});
        check("exc_m_halted", {31'd0, halted}, 32'd0);
        advance();
        idle(); W_stat = SADR;
        eval();
        check("drain_ctl", {26'd0, ctl_vec()}, {26'd0, 6'b000011});
        advance();
        idle();
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin E_icode = IMRMOVL; E_dstM = 8'd2; d_srcB = 8'd2; end
            eval();
            check("halt_halted", {31'd0, halted}, 32'd1);
            check("halt_ctl", {26'd0, ctl_vec()}, {26'd0, 6'b110111});
            check("halt_stall_cnt", stall_cnt, 32'd5);
            check("halt_bubble_cnt", bubble_cnt, 32'd5);
            advance();
        end

        // ---------------- Reset while halted ----------------
        idle(); rst = 1'b1;
        eval();
        check("rst_halt_ctl", {26'd0, ctl_vec()}, 32'd0);
        check("rst_halt_halted", {31'd0, halted}, 32'd0);
        advance();
        idle();
        eval();
        check("rst_halt_state", {31'd0, halted}, 32'd0);
        check("rst_halt_stall", stall_cnt, 32'd0);
        check("rst_halt_bubble", bubble_cnt, 32'd0);
        advance();

        // ---------------- Saturation ----------------
        force dut.u_stall_cnt.cnt_q = 32'hFFFF_FFFE;
        #1 release dut.u_stall_cnt.cnt_q;
        m_stall = 32'hFFFF_FFFE;
        E_icode = IPOPL; E_dstM = 8'd6; d_srcA = 8'd6;
        eval();
        check("sat_pre", stall_cnt, 32'hFFFF_FFFE);
        advance();
        eval();
        check("sat_hit", stall_cnt, 32'hFFFF_FFFF);
        advance();
        eval();
        check("sat_hold", stall_cnt, 32'hFFFF_FFFF);
        advance();
        idle();
        eval();
        check("sat_after", stall_cnt, 32'hFFFF_FFFF);
        advance();

        // ---------------- Random traffic ----------------
        for (int n = 0; n < 1500; n++) begin
            idle();
            rst     = ($urandom_range(0, 49) == 0);
            D_icode = icodes[$urandom_range(0, 5)];
            E_icode = icodes[$urandom_range(0, 5)];
            M_icode = icodes[$urandom_range(0, 5)];
            if (D_icode == 8'h00) D_icode = 8'($urandom);
            d_srcA  = ($urandom_range(0, 3) == 0) ? RNONE : 8'($urandom_range(0, 3));
            d_srcB  = ($urandom_range(0, 3) == 0) ? RNONE : 8'($urandom_range(0, 3));
            E_dstM  = ($urandom_range(0, 3) == 0) ? RNONE : 8'($urandom_range(0, 3));
            e_Cnd   = 1'($urandom);
            m_stat  = ($urandom_range(0, 29) == 0) ? 8'($urandom_range(0, 5)) : SAOK;
            W_stat  = ($urandom_range(0, 39) == 0) ? 8'($urandom_range(0, 5)) : SAOK;
            eval();
            advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_pipe_ctrl
`default_nettype wire

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The module SHALL have a clock port: clk  in  1  pipeline clock; all state updates occur on its rising edge.
REQ-002 The module SHALL have a reset port: rst  in  1  reset, synchronous and active-high.
REQ-003 The module SHALL have input D_icode_i  in  `BYTE  icode held in the decode register.
REQ-004 The module SHALL have inputs d_srcA_i and d_srcB_i  in  `BYTE  each  decode source register IDs (RNONE=0xF when unused).
REQ-005 The module SHALL have inputs E_icode_i and E_dstM_i  in  `BYTE  each  execute-stage icode and memory destination register.
REQ-006 The module SHALL have input e_Cnd_i  in  1  branch condition computed in execute.
REQ-007 The module SHALL have input M_icode_i  in  `BYTE  memory-stage icode.
REQ-008 The module SHALL have inputs m_stat_i and W_stat_i  in  `BYTE  each  memory-stage result status and writeback-stage status.
REQ-009 The module SHALL have outputs F_stall_o, D_stall_o, D_bubble_o, E_bubble_o, M_bubble_o and W_stall_o  out  1  each  pipeline register controls (`ENABLE/`DISABLE).
REQ-010 The module SHALL have output halted_o  out  1  asserted when the state is HALT.
REQ-011 The module SHALL have outputs stall_cnt_o and bubble_cnt_o  out  `WORD  each  performance counters.

Function
REQ-012 Define load_use = (E_icode_i is IMRMOVL or IPOPL) and E_dstM_i != RNONE and E_dstM_i is equal to d_srcA_i or d_srcB_i.
REQ-013 Define ret_inflight = IRET present in any of D_icode_i, E_icode_i or M_icode_i.
REQ-014 Define mispred = E_icode_i == IJXX and e_Cnd_i == 0.
REQ-015 Define m_exc = m_stat_i is SADR, SINS or SHLT; define w_exc = W_stat_i is SADR, SINS or SHLT (SAOK=1, SHLT=2, SADR=3, SINS=4).
REQ-016 In state RUN, the control outputs SHALL be combinational and same-cycle: F_stall = load_use | ret_inflight.
REQ-017 In state RUN, D_stall SHALL equal load_use.
REQ-018 In state RUN, D_bubble SHALL equal mispred | (ret_inflight & ~load_use).
REQ-019 In state RUN, E_bubble SHALL equal mispred | load_use.
REQ-020 In state RUN, M_bubble SHALL equal m_exc | w_exc.
REQ-021 In state RUN, W_stall SHALL equal w_exc.
REQ-022 The block SHALL guarantee that D_stall and D_bubble are never both asserted; load_use has priority over ret_inflight.
REQ-023 On simultaneous mispred and ret_inflight, the block SHALL assert F_stall, D_bubble and E_bubble and keep D_stall deasserted.
REQ-024 The FSM SHALL have states RUN, DRAIN and HALT, encoded in 2 bits.
REQ-025 The FSM SHALL transition RUN->DRAIN when m_exc=1 and w_exc=0, and RUN->HALT when w_exc=1.
REQ-026 The FSM SHALL transition DRAIN->HALT when w_exc=1; DRAIN SHALL otherwise persist.
REQ-027 HALT SHALL be sticky until rst.
REQ-028 In DRAIN, the block SHALL assert M_bubble every cycle, with the other outputs following the RUN equations.
REQ-029 In HALT, the block SHALL force F_stall=D_stall=W_stall=1, E_bubble=M_bubble=1 and D_bubble=0.
REQ-030 stall_cnt SHALL increment by 1 on each cycle in which F_stall or D_stall is asserted and the state is not HALT.
REQ-031 bubble_cnt SHALL increment by 1 on each cycle in which D_bubble or E_bubble is asserted and the state is not HALT.
REQ-032 Both counters SHALL be 32-bit and saturating at 0xFFFFFFFF (no wrap).
REQ-033 Counter increments SHALL use the outputs as actually driven in that cycle.

Reset
REQ-034 When rst=1 at a rising clk edge, state SHALL become RUN and stall_cnt and bubble_cnt SHALL become 0, overriding any pending transition or increment.
REQ-035 While rst=1, all six control outputs SHALL be forced to 0 and halted_o SHALL be 0.
REQ-036 A reset in DRAIN or HALT SHALL return the block to RUN on the next edge.

Structure
REQ-037 Icode constants (INOP, IJXX, IMRMOVL, IPOPL, IRET), RNONE, the stat codes, `ENABLE/`DISABLE, `BYTE and `WORD SHALL reside in the shared defines.v.
REQ-038 The FSM state encodings SHALL reside in the shared defines.v.
REQ-039 One sub-module, sat_counter (32-bit saturating, inc/clear inputs), SHALL be instantiated twice.

Verification
REQ-040 The bench SHALL cover load-use: E_icode=IMRMOVL, E_dstM=3, d_srcA=3 -> F_stall=1, D_stall=1, E_bubble=1, D_bubble=0, stall_cnt +1.
REQ-041 The bench SHALL cover ret: D_icode=IRET for three consecutive cycles as it moves D->E->M -> F_stall=1 and D_bubble=1 each cycle, and bubble_cnt +3.
REQ-042 The bench SHALL cover mispredict with ret in D: E_icode=IJXX, e_Cnd=0, D_icode=IRET -> F_stall=1, D_bubble=1, E_bubble=1, D_stall=0.
REQ-043 The bench SHALL cover the exception path: m_stat=SADR one cycle, then W_stat=SADR -> DRAIN with M_bubble=1, then HALT with halted_o=1, W_stall=1, and counters frozen.
REQ-044 The bench SHALL cover saturation: preload stall_cnt=0xFFFFFFFE and hold load_use for 3 cycles -> stall_cnt=0xFFFFFFFF and stays there.
REQ-045 The bench SHALL cover reset mid-HALT: rst=1 for 1 cycle -> state RUN, counters 0, all controls 0 during rst.
